hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5: register-address width.
REQ-002 Parameter FWD_STAGES, default 3, legal range 2..4: number of forwarding source stages; index 0=EX, 1=MEM, 2=WB, 3=extra.
REQ-003 Parameter LOAD_LAT, default 1, legal range 1..FWD_STAGES-1: lowest stage index at which load data may be forwarded.
REQ-004 Parameter CNT_W, default 32: performance-counter width.
REQ-005 Port clk  in  1  the single clock; reset is synchronous and active-high.
REQ-006 Port rst  in  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-007 Ports rs1, rs2  in  REG_AW each  ID-stage source register addresses.
REQ-008 Ports rs1_used, rs2_used  in  1 each  the source is actually read by the ID instruction.
REQ-009 Port id_valid  in  1  the ID stage holds a real instruction.
REQ-010 Port st_we  in  FWD_STAGES  per-stage register-write enable; bit i belongs to stage i.
REQ-011 Port st_waddr  in  FWD_STAGES*REG_AW  per-stage destination register; slice i belongs to stage i.
REQ-012 Port st_load  in  FWD_STAGES  the per-stage instruction is a load.
REQ-013 Port ex_redirect  in  1  taken branch or jump resolved in EX.
REQ-014 Port perf_clr  in  1  clears both performance counters.
REQ-015 Ports fwd_sel1, fwd_sel2  out  $clog2(FWD_STAGES+1) each  0=register file, i+1=stage i.
REQ-016 Port stall_pc  out  1  hold the PC and the IF/ID register.
REQ-017 Port flush_if_id  out  1  squash IF/ID.
REQ-018 Port flush_id_ex  out  1  insert a bubble into ID/EX.
REQ-019 Ports stall_cycles, flush_count  out  CNT_W each  performance counters.

Function
REQ-020 Source match for stage i, per source: st_we[i]=1, st_waddr slice i equals rs, rs!=0, rs_used=1, and id_valid=1.
REQ-021 fwd_sel SHALL select the lowest-index matching stage; if no stage matches, fwd_sel SHALL be 0.
REQ-022 A match whose lowest-index stage i has st_load[i]=1 and i<LOAD_LAT is a load-use hazard; in that case fwd_sel SHALL be 0 and need=LOAD_LAT-i.
REQ-023 Per-cycle need SHALL be the maximum of the rs1 and rs2 need values; need=0 means no hazard.
REQ-024 The FSM SHALL have two states: RUN and STALL, with a down-counter scnt of width $clog2(FWD_STAGES)+1.
REQ-025 In RUN with need>0 and ex_redirect=0: stall_pc=1 and flush_id_ex=1 in the same cycle; scnt<=need-1; next state is STALL if need>1, else RUN.
REQ-026 In STALL: stall_pc=1 and flush_id_ex=1 regardless of the detector output; scnt decrements each cycle; when scnt==1, next state is RUN.
REQ-027 ex_redirect=1 in any state SHALL take priority: flush_if_id=1, flush_id_ex=1, stall_pc=0 in the same cycle; next state RUN and scnt<=0.
REQ-028 With no hazard and no redirect: all control outputs SHALL be 0 (combinational, zero latency).
REQ-029 stall_cycles SHALL increment every cycle in which stall_pc=1; flush_count SHALL increment every cycle in which ex_redirect=1.
REQ-030 Both counters SHALL saturate at all-ones with no wrap.
REQ-031 perf_clr=1 SHALL zero both counters next cycle and takes priority over a same-cycle increment.

Reset
REQ-032 rst=1 SHALL force state RUN, scnt=0, stall_cycles=0, flush_count=0.
REQ-033 While rst=1, all control outputs SHALL be 0 and fwd_sel1=fwd_sel2=0, including a reset asserted mid-stall.

Structure
REQ-034 Package hazard_pkg SHALL hold the fwd_sel encodings (FWD_RF=0), the FSM state enum, and the opcode constants shared with the decoder.
REQ-035 One sub-module, hazard_src_match, SHALL be instantiated twice (once each for rs1 and rs2) and SHALL return sel and need for one source.
REQ-036 All sequential logic SHALL live in hazard_ctrl, in a single always block clocked on posedge clk.

Verification
REQ-037 Defaults, rs1=5, stage0 we=1 waddr=5 not load -> fwd_sel1=1, no stall.
REQ-038 rs2=7 matches stage0 and stage1 -> fwd_sel2=1 (youngest stage wins); rs=0 matching any stage -> fwd_sel=0.
REQ-039 LOAD_LAT=2, rs1=3 matches a load in stage0 -> stall_pc=1 and flush_id_ex=1 for exactly 2 cycles; stall_cycles increases by 2.
REQ-040 ex_redirect asserted in the 1st cycle of a 2-cycle stall -> flush_if_id=1, stall_pc=0 that cycle, state RUN next cycle; flush_count increases by 1.
REQ-041 CNT_W=4, 20 stall cycles -> stall_cycles=15 (saturated); perf_clr together with a stall -> counter reads 0 next cycle.
REQ-042 rst=1 asserted during STALL -> all outputs 0 in that cycle and state RUN after reset is released.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding-select
// encodings, controller FSM states and the opcode constants used by the decoder.
package hazard_pkg;

  localparam int FWD_RF  = 0;
  localparam int FWD_EX  = 1;
  localparam int FWD_MEM = 2;
  localparam int FWD_WB  = 3;
  localparam int FWD_X   = 4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } hz_state_e;

  // Major opcodes shared with the decoder (RV32I encoding).
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

endpackage

// File: rtl/hazard_src_match.sv
// Per-source hazard detector: picks the youngest matching producer stage and
// reports either a forwarding select or the number of stall cycles needed.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 3,
  parameter int LOAD_LAT   = 1,
  localparam int SEL_W     = $clog2(FWD_STAGES + 1),
  localparam int NEED_W    = $clog2(FWD_STAGES) + 1
) (
  input  logic [REG_AW-1:0]            rs,
  input  logic                         rs_used,
  input  logic                         id_valid,
  input  logic [FWD_STAGES-1:0]        st_we,
  input  logic [FWD_STAGES*REG_AW-1:0] st_waddr,
  input  logic [FWD_STAGES-1:0]        st_load,
  output logic [SEL_W-1:0]             sel,
  output logic [NEED_W-1:0]            need
);

  logic [FWD_STAGES-1:0] hit;

  generate
    for (genvar gi = 0; gi < FWD_STAGES; gi++) begin : g_hit
      assign hit[gi] = st_we[gi] && (st_waddr[gi*REG_AW +: REG_AW] == rs) &&
                       (rs != '0) && rs_used && id_valid;
    end
  endgenerate

  // Walk oldest to youngest so the lowest-index match is the one that sticks.
  always_comb begin
    sel  = SEL_W'(FWD_RF);
    need = '0;
    for (int i = FWD_STAGES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        if (st_load[i] && (i < LOAD_LAT)) begin
          sel  = SEL_W'(FWD_RF);
          need = NEED_W'(LOAD_LAT - i);
        end else begin
          sel  = SEL_W'(i + 1);
          need = '0;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding selects, load-use stall FSM,
// EX redirect flushes and saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 3,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 32,
  localparam int SEL_W     = $clog2(FWD_STAGES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REG_AW-1:0]            rs1,
  input  logic [REG_AW-1:0]            rs2,
  input  logic                         rs1_used,
  input  logic                         rs2_used,
  input  logic                         id_valid,
  input  logic [FWD_STAGES-1:0]        st_we,
  input  logic [FWD_STAGES*REG_AW-1:0] st_waddr,
  input  logic [FWD_STAGES-1:0]        st_load,
  input  logic                         ex_redirect,
  input  logic                         perf_clr,
  output logic [SEL_W-1:0]             fwd_sel1,
  output logic [SEL_W-1:0]             fwd_sel2,
  output logic                         stall_pc,
  output logic                         flush_if_id,
  output logic                         flush_id_ex,
  output logic [CNT_W-1:0]             stall_cycles,
  output logic [CNT_W-1:0]             flush_count
);

  localparam int NEED_W = $clog2(FWD_STAGES) + 1;

  logic [SEL_W-1:0]  sel1, sel2;
  logic [NEED_W-1:0] need1, need2, need;

  hz_state_e         state_reg;
  logic [NEED_W-1:0] scnt_reg;
  logic [CNT_W-1:0]  stall_cnt_reg, flush_cnt_reg;

  hazard_src_match #(.REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES), .LOAD_LAT(LOAD_LAT)) u_rs1 (
    .rs(rs1), .rs_used(rs1_used), .id_valid(id_valid), .st_we(st_we),
    .st_waddr(st_waddr), .st_load(st_load), .sel(sel1), .need(need1)
  );

  hazard_src_match #(.REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES), .LOAD_LAT(LOAD_LAT)) u_rs2 (
    .rs(rs2), .rs_used(rs2_used), .id_valid(id_valid), .st_we(st_we),
    .st_waddr(st_waddr), .st_load(st_load), .sel(sel2), .need(need2)
  );

  assign need = (need1 > need2) ? need1 : need2;

  // Control outputs react in the same cycle; reset masks everything, then redirect wins.
  always_comb begin
    fwd_sel1    = sel1;
    fwd_sel2    = sel2;
    stall_pc    = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (rst) begin
      fwd_sel1 = SEL_W'(FWD_RF);
      fwd_sel2 = SEL_W'(FWD_RF);
    end else if (ex_redirect) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if ((state_reg == ST_STALL) || (need != '0)) begin
      stall_pc    = 1'b1;
      flush_id_ex = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_RUN;
      scnt_reg      <= '0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (ex_redirect) begin
        state_reg <= ST_RUN;
        scnt_reg  <= '0;
      end else if (state_reg == ST_STALL) begin
        scnt_reg <= scnt_reg - NEED_W'(1);
        if (scnt_reg == NEED_W'(1)) state_reg <= ST_RUN;
      end else if (need != '0) begin
        scnt_reg  <= need - NEED_W'(1);
        state_reg <= (need > NEED_W'(1)) ? ST_STALL : ST_RUN;
      end

      if (perf_clr) begin
        stall_cnt_reg <= '0;
        flush_cnt_reg <= '0;
      end else begin
        if (stall_pc && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        if (ex_redirect && (flush_cnt_reg != '1)) flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_cnt_reg;
  assign flush_count  = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int AW   = 5;
  localparam int NS   = 3;
  localparam int LL   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs1, rs2;
  logic          rs1_used, rs2_used, id_valid;
  logic [NS-1:0] st_we, st_load;
  logic [NS*AW-1:0] st_waddr;
  logic          ex_redirect, perf_clr;
  logic [1:0]    fwd_sel1, fwd_sel2;
  logic          stall_pc, flush_if_id, flush_id_ex;
  logic [CW-1:0] stall_cycles, flush_count;
  logic [2:0]    ctl;

  int checks = 0;
  int failures = 0;

  // Model state: remaining stall cycles and counter values
  int m_rem, m_stall, m_flush;

  assign ctl = {stall_pc, flush_if_id, flush_id_ex};

  hazard_ctrl #(.REG_AW(AW), .FWD_STAGES(NS), .LOAD_LAT(LL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .id_valid(id_valid), .st_we(st_we), .st_waddr(st_waddr), .st_load(st_load),
    .ex_redirect(ex_redirect), .perf_clr(perf_clr), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .stall_pc(stall_pc), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 1'b0; rs1 = '0; rs2 = '0; rs1_used = 1'b0; rs2_used = 1'b0; id_valid = 1'b0;
    st_we = '0; st_waddr = '0; st_load = '0; ex_redirect = 1'b0; perf_clr = 1'b0;
  endtask

  task automatic set_stage(input int i, input logic we, input logic [AW-1:0] addr, input logic ld);
    st_we[i] = we;
    st_waddr[i*AW +: AW] = addr;
    st_load[i] = ld;
  endtask

  task automatic use_src(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rs1 = a1; rs2 = a2; rs1_used = 1'b1; rs2_used = 1'b1; id_valid = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk); idle(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // Reference for one source: youngest producer wins; a too-young load asks for a stall.
  function automatic void src_ref(input logic [AW-1:0] rs, input logic used, output int sel, output int need);
    sel = 0; need = 0;
    if (id_valid && used && rs != 0) begin
      for (int i = 0; i < NS; i++) begin
        if (st_we[i] && st_waddr[i*AW +: AW] == rs) begin
          if (st_load[i] && i < LL) need = LL - i;
          else sel = i + 1;
          break;
        end
      end
    end
  endfunction

  task automatic test_reset();
    @(negedge clk); idle(); rst = 1'b1; ex_redirect = 1'b1; use_src(3, 7);
    set_stage(0, 1, 3, 1); set_stage(1, 1, 7, 0);
    #1;
    checks++; if (ctl !== 3'b000) begin failures++; $display("FAIL reset_ctl got=%b exp=000", ctl); end
    checks++; if (fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd0) begin failures++; $display("FAIL reset_fwd got=%0d/%0d exp=0/0", fwd_sel1, fwd_sel2); end
    @(negedge clk); #1;
    checks++; if (stall_cycles !== 4'd0 || flush_count !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cycles, flush_count); end
    $display("test_reset done");
  endtask

  task automatic test_forward();
    do_reset();
    @(negedge clk); idle(); use_src(5, 0); set_stage(0, 1, 5, 0); #1;
    checks++; if (fwd_sel1 !== 2'd1 || ctl !== 3'b000) begin failures++; $display("FAIL fwd_ex got=%0d ctl=%b exp=1 ctl=000", fwd_sel1, ctl); end
    @(negedge clk); idle(); use_src(0, 7); set_stage(0, 1, 7, 0); set_stage(1, 1, 7, 0); #1;
    checks++; if (fwd_sel2 !== 2'd1 || ctl !== 3'b000) begin failures++; $display("FAIL fwd_youngest got=%0d exp=1", fwd_sel2); end
    @(negedge clk); idle(); use_src(0, 0); set_stage(0, 1, 0, 0); set_stage(1, 1, 0, 1); set_stage(2, 1, 0, 0); #1;
    checks++; if (fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd0 || ctl !== 3'b000) begin failures++; $display("FAIL fwd_r0 got=%0d/%0d exp=0/0", fwd_sel1, fwd_sel2); end
    @(negedge clk); idle(); use_src(9, 12); set_stage(1, 1, 9, 0); set_stage(2, 1, 12, 1); #1;
    checks++; if (fwd_sel1 !== 2'd2 || fwd_sel2 !== 2'd3) begin failures++; $display("FAIL fwd_mem_wb got=%0d/%0d exp=2/3", fwd_sel1, fwd_sel2); end
    rs1_used = 1'b0; #1;
    checks++; if (fwd_sel1 !== 2'd0) begin failures++; $display("FAIL fwd_unused got=%0d exp=0", fwd_sel1); end
    $display("test_forward done");
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk); idle(); use_src(3, 0); set_stage(0, 1, 3, 1); #1;
    checks++; if (ctl !== 3'b101 || fwd_sel1 !== 2'd0) begin failures++; $display("FAIL lu_c1 got=%b sel=%0d exp=101 sel=0", ctl, fwd_sel1); end
    @(negedge clk); set_stage(0, 0, 0, 0); set_stage(1, 1, 3, 1); #1;
    checks++; if (ctl !== 3'b101) begin failures++; $display("FAIL lu_c2 got=%b exp=101", ctl); end
    @(negedge clk); set_stage(1, 0, 0, 0); set_stage(2, 1, 3, 1); #1;
    checks++; if (ctl !== 3'b000 || fwd_sel1 !== 2'd3) begin failures++; $display("FAIL lu_c3 got=%b sel=%0d exp=000 sel=3", ctl, fwd_sel1); end
    checks++; if (stall_cycles !== 4'd2) begin failures++; $display("FAIL lu_count got=%0d exp=2", stall_cycles); end
    $display("test_load_use done");
  endtask

  task automatic test_redirect();
    do_reset();
    @(negedge clk); idle(); use_src(3, 0); set_stage(0, 1, 3, 1); ex_redirect = 1'b1; #1;
    checks++; if (ctl !== 3'b011) begin failures++; $display("FAIL rd_run got=%b exp=011", ctl); end
    @(negedge clk); idle(); #1;
    checks++; if (ctl !== 3'b000 || flush_count !== 4'd1 || stall_cycles !== 4'd0) begin failures++; $display("FAIL rd_after got=%b f=%0d s=%0d exp=000 f=1 s=0", ctl, flush_count, stall_cycles); end
    @(negedge clk); use_src(3, 0); set_stage(0, 1, 3, 1); #1;
    checks++; if (ctl !== 3'b101) begin failures++; $display("FAIL rd_stall got=%b exp=101", ctl); end
    @(negedge clk); idle(); ex_redirect = 1'b1; #1;
    checks++; if (ctl !== 3'b011) begin failures++; $display("FAIL rd_in_stall got=%b exp=011", ctl); end
    @(negedge clk); idle(); #1;
    checks++; if (ctl !== 3'b000 || flush_count !== 4'd2 || stall_cycles !== 4'd1) begin failures++; $display("FAIL rd_end got=%b f=%0d s=%0d exp=000 f=2 s=1", ctl, flush_count, stall_cycles); end
    $display("test_redirect done");
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); idle(); use_src(3, 0); set_stage(1, 1, 3, 1); #1;
      checks++; if (ctl !== 3'b101) begin failures++; $display("FAIL sat_stall%0d got=%b exp=101", k, ctl); end
    end
    @(negedge clk); perf_clr = 1'b1; #1;
    checks++; if (stall_cycles !== 4'd15) begin failures++; $display("FAIL sat_value got=%0d exp=15", stall_cycles); end
    @(negedge clk); perf_clr = 1'b0; #1;
    checks++; if (stall_cycles !== 4'd0 || ctl !== 3'b101) begin failures++; $display("FAIL sat_clr got=%0d exp=0", stall_cycles); end
    @(negedge clk); #1;
    checks++; if (stall_cycles !== 4'd1) begin failures++; $display("FAIL sat_resume got=%0d exp=1", stall_cycles); end
    $display("test_saturate done");
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    @(negedge clk); idle(); use_src(3, 7); set_stage(0, 1, 3, 1); set_stage(2, 1, 7, 0); #1;
    checks++; if (ctl !== 3'b101 || fwd_sel2 !== 2'd3) begin failures++; $display("FAIL rms_pre got=%b sel2=%0d exp=101 sel2=3", ctl, fwd_sel2); end
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (ctl !== 3'b000 || fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd0) begin failures++; $display("FAIL rms_rst got=%b sel=%0d/%0d exp=000 0/0", ctl, fwd_sel1, fwd_sel2); end
    @(negedge clk); idle(); #1;
    checks++; if (ctl !== 3'b000 || stall_cycles !== 4'd0) begin failures++; $display("FAIL rms_after got=%b s=%0d exp=000 s=0", ctl, stall_cycles); end
    $display("test_reset_mid_stall done");
  endtask

  task automatic test_random();
    int s1, n1, s2, n2, need;
    logic [2:0] exp_ctl;
    m_rem = 0; m_stall = 0; m_flush = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst = (n == 0) || ($urandom_range(0, 59) == 0);
      rs1 = AW'($urandom_range(0, 7)); rs2 = AW'($urandom_range(0, 7));
      rs1_used = 1'($urandom_range(0, 1)); rs2_used = 1'($urandom_range(0, 1));
      id_valid = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < NS; i++) set_stage(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      ex_redirect = ($urandom_range(0, 7) == 0);
      perf_clr = ($urandom_range(0, 19) == 0);
      #1;
      src_ref(rs1, rs1_used, s1, n1);
      src_ref(rs2, rs2_used, s2, n2);
      need = (n1 > n2) ? n1 : n2;
      if (rst) begin s1 = 0; s2 = 0; exp_ctl = 3'b000; end
      else if (ex_redirect) exp_ctl = 3'b011;
      else if (m_rem > 0 || need > 0) exp_ctl = 3'b101;
      else exp_ctl = 3'b000;
      $display("txn %0d rst=%0b rs=%0d/%0d need=%0d ctl=%b sel=%0d/%0d cnt=%0d/%0d", n, rst, rs1, rs2, need, ctl, fwd_sel1, fwd_sel2, stall_cycles, flush_count);
      checks++; if (fwd_sel1 !== 2'(s1) || fwd_sel2 !== 2'(s2)) begin failures++; $display("FAIL rnd_fwd%0d got=%0d/%0d exp=%0d/%0d", n, fwd_sel1, fwd_sel2, s1, s2); end
      checks++; if (ctl !== exp_ctl) begin failures++; $display("FAIL rnd_ctl%0d got=%b exp=%b", n, ctl, exp_ctl); end
      checks++; if (stall_cycles !== CW'(m_stall) || flush_count !== CW'(m_flush)) begin failures++; $display("FAIL rnd_cnt%0d got=%0d/%0d exp=%0d/%0d", n, stall_cycles, flush_count, m_stall, m_flush); end
      if (rst) begin
        m_rem = 0; m_stall = 0; m_flush = 0;
      end else begin
        if (ex_redirect) m_rem = 0;
        else if (m_rem > 0) m_rem--;
        else if (need > 0) m_rem = need - 1;
        if (perf_clr) begin
          m_stall = 0; m_flush = 0;
        end else begin
          if (exp_ctl[2] && m_stall < CMAX) m_stall++;
          if (ex_redirect && m_flush < CMAX) m_flush++;
        end
      end
    end
    $display("test_random done");
  endtask

  initial begin
    idle();
    test_reset();
    test_forward();
    test_load_use();
    test_redirect();
    test_saturate();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
